// File: rtl/serializador_resultado.sv
// Result matrix serializer: captures a packed DIM x DIM signed matrix on a start
// pulse and streams it row-major, one element per valid/ready handshake.
// Optional feature macro: MATRIZ_TAMANHO_EN (stream only the top-left size x size block).
module serializador_resultado #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned DIM    = 5,
    parameter int unsigned IDX_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DIM*DIM*ELEM_W-1:0]   matriz_in,
    input  logic [2:0]                  size_in,
    output logic [ELEM_W-1:0]           dado_out,
    output logic [IDX_W-1:0]            idx_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        last_out,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned MAT_W = DIM * DIM * ELEM_W;

    typedef enum logic [1:0] {StIdle, StSend, StFim} state_e;

    state_e              state_q, state_d;
    logic [MAT_W-1:0]    shadow_q, shadow_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic [ELEM_W-1:0]   dado_q, dado_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Active size for the current stream and the value captured on start.
    logic [2:0]          size_cur;
    logic [2:0]          size_cap;

`ifdef MATRIZ_TAMANHO_EN
    logic [2:0]          size_q, size_d;

    // Out-of-range sizes (0, 1, above DIM) fall back to the full matrix.
    always_comb begin
        if (size_in >= 3'd2 && size_in <= 3'(DIM)) begin
            size_cap = size_in;
        end else begin
            size_cap = 3'(DIM);
        end
    end

    assign size_cur = size_q;

    // Size register, captured together with the matrix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q <= 3'(DIM);
        end else begin
            size_q <= size_d;
        end
    end

    // Size only changes on an accepted start.
    always_comb begin
        size_d = size_q;
        if (state_q == StIdle && start) begin
            size_d = size_cap;
        end
    end
`else
    logic unused_size_in;

    assign unused_size_in = ^size_in;
    assign size_cap       = 3'(DIM);
    assign size_cur       = 3'(DIM);
`endif

    function automatic logic [IDX_W-1:0] idx_of(input logic [2:0] r, input logic [2:0] c);
        return IDX_W'(32'(r) * DIM + 32'(c));
    endfunction

    logic [2:0]        row_nx;
    logic [2:0]        col_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic              last_nx;

    // Position of the beat that follows the current one in the active block.
    always_comb begin
        row_nx = row_q;
        col_nx = col_q + 3'd1;
        if (col_q == size_cur - 3'd1) begin
            col_nx = 3'd0;
            row_nx = row_q + 3'd1;
        end
        idx_nx  = idx_of(row_nx, col_nx);
        last_nx = (row_nx == size_cur - 3'd1) && (col_nx == size_cur - 3'd1);
    end

    // Next-state and next-output logic; all outputs come from registers.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        row_d    = row_q;
        col_d    = col_q;
        dado_d   = dado_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shadow_d = matriz_in;
                    row_d    = 3'd0;
                    col_d    = 3'd0;
                    dado_d   = matriz_in[ELEM_W-1:0];
                    idx_d    = '0;
                    valid_d  = 1'b1;
                    last_d   = (size_cap == 3'd1);
                    busy_d   = 1'b1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (ready_in) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFim;
                    end else begin
                        row_d  = row_nx;
                        col_d  = col_nx;
                        idx_d  = idx_nx;
                        dado_d = shadow_q[32'(idx_nx) * ELEM_W +: ELEM_W];
                        last_d = last_nx;
                    end
                end
            end
            StFim: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, shadow matrix and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            dado_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dado_q   <= dado_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dado_out  = dado_q;
    assign idx_out   = idx_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
